// File: rtl/md_pkg.sv
// Shared encodings and sizing for the multiply/divide controller.
// Holds the md_op codes, default latencies, counter width and the FSM state type.
package md_pkg;

   localparam int CNT_W           = 4;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // Multi-cycle ops are the ones that occupy the unit and must stall ID.
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag.
// Zero latency; no handshake, the controller samples the result at accept.
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [63:0] res,
   output logic        div_zero
);

   logic signed [63:0] rs_sx;
   logic signed [63:0] rt_sx;
   logic        [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_signed;
   logic               neg_a;
   logic               neg_b;
   logic        [31:0] mag_a;
   logic        [31:0] mag_b;
   logic        [31:0] mag_b_safe;
   logic        [31:0] q_mag;
   logic        [31:0] r_mag;
   logic        [31:0] quot;
   logic        [31:0] rem;

   assign rs_sx  = {{32{rs_val[31]}}, rs_val};
   assign rt_sx  = {{32{rt_val[31]}}, rt_val};
   assign prod_s = rs_sx * rt_sx;
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly to
   // 0x80000000 and the quotient truncates toward zero.
   assign div_signed = (md_op == MD_DIV);
   assign neg_a      = div_signed & rs_val[31];
   assign neg_b      = div_signed & rt_val[31];
   assign mag_a      = neg_a ? -rs_val : rs_val;
   assign mag_b      = neg_b ? -rt_val : rt_val;
   assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign q_mag      = mag_a / mag_b_safe;
   assign r_mag      = mag_a % mag_b_safe;
   assign quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
   assign rem        = neg_a ? -r_mag : r_mag;

   always_comb begin
      res      = 64'd0;
      div_zero = 1'b0;
      case (md_op)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV, MD_DIVU: begin
            div_zero = (rt_val == 32'd0);
            res      = {rem, quot};
         end
         default: res = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: fixed-latency FSM, result buffer and HI/LO registers.
// MULT_CYCLES/DIV_CYCLES busy cycles; starts while busy are dropped, md_stall holds ID.
module md_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        id_is_md,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_dz;
   logic [63:0]      calc_res;
   logic             calc_dz;

   md_calc u_calc (
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .res      (calc_res),
      .div_zero (calc_dz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         res_dz <= 1'b0;
         busy   <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (md_op)
                     MD_MULT, MD_MULTU: begin
                        {res_hi, res_lo} <= calc_res;
                        res_dz           <= 1'b0;
                        cnt              <= CNT_W'(MULT_CYCLES);
                        state            <= ST_BUSY;
                        busy             <= 1'b1;
                     end
                     MD_DIV, MD_DIVU: begin
                        {res_hi, res_lo} <= calc_res;
                        res_dz           <= calc_dz;
                        cnt              <= CNT_W'(DIV_CYCLES);
                        state            <= ST_BUSY;
                        busy             <= 1'b1;
                     end
                     MD_MTHI: hi <= rs_val;
                     MD_MTLO: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               // A divide by zero still burns its full latency but never commits.
               if (cnt == CNT_W'(1)) begin
                  if (!res_dz) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
                  cnt   <= '0;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign md_stall = id_is_md && (busy || (start && is_long_op(md_op)));

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` from EX, counts out the fixed operation latency, and owns the HI/LO registers. It produces the `busy`/`md_stall` signal that the hazard unit consumes as its global stall input, so ID-stage HI/LO users wait until results commit.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: EX holds a valid MD instruction this cycle.
- `md_op` in 3: operation code, encoded in `md_pkg`: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- `rs_val` in 32: forwarded EX rs operand.
- `rt_val` in 32: forwarded EX rt operand.
- `id_is_md` in 1: ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy` out 1: an operation is in flight.
- `md_stall` out 1: stall request to the hazard unit.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation

- States: IDLE and BUSY, plus a 4-bit down-counter `cnt`.
- **Accept:** an operation is accepted at a rising edge where `start`=1 and the state is IDLE. When `start`=1 in BUSY, the operation is ignored. The bench asserts this never happens.
- **MULT/MULTU:** at accept, latch the 64-bit product of `rs_val` and `rt_val` (signed or unsigned) into `res_hi`/`res_lo`. Set `cnt`=`MULT_CYCLES` and go to BUSY.
- **DIV/DIVU:**
  - At accept, latch quotient to `res_lo` and remainder to `res_hi`. Set `cnt`=`DIV_CYCLES` and go to BUSY.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
  - Divisor 0: the operation still runs the full `DIV_CYCLES`, but HI/LO stay unchanged at commit.
- **MTHI/MTLO:** when accepted in IDLE, `hi` (or `lo`) is loaded with `rs_val` at that edge. State stays IDLE and `busy` is not raised.
- **BUSY:** `cnt` decrements each edge. At the edge where `cnt`==1, HI/LO take `res_hi`/`res_lo` (unless divide-by-zero), `cnt` becomes 0 and the state returns to IDLE.
- **`busy`** is registered and equals (state==BUSY).
- **`md_stall`** is combinational: `id_is_md` && (`busy` || (`start` && `md_op` in MULT..DIVU)).
- **`md_op`=NONE** with `start`=1 is a no-op.

## Timing

- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE, `cnt`=0, `res_hi`=`res_lo`=0.
- **Reset mid-operation:** aborts the operation; no commit occurs, and the reset values apply at the next edge.
- **Multiply latency:** accept at edge E0. `busy`=1 from after E0 through the cycle before E(N), with N=`MULT_CYCLES`. HI/LO update at E(N), and `busy`=0 after E(N).
- **Divide latency:** identical, with N=`DIV_CYCLES`.
- An `mfhi` in ID during the busy cycles (or the accept cycle) sees `md_stall`=1. The first non-stalled cycle reads the committed values.
- **Back-to-back:** a new `start` arriving in the cycle right after commit (state IDLE) is accepted with no bubble.
- **Simultaneous commit edge and reset:** reset wins.

## Structure

- Package `md_pkg` holds:
  - the `md_op` encoding constants;
  - the default cycle counts;
  - the `cnt` width (4).
- Sub-module `md_calc`: purely combinational. Inputs are `md_op`, `rs_val`, `rt_val`. Outputs are 64-bit {`hi`,`lo`} result and a `div_zero` flag.
- `md_ctrl` holds the FSM, counter, result buffer and HI/LO registers.

## Test plan

- **MULT signed:** MULT rs=0xFFFFFFFF, rt=2.
  - `busy` high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- **MULTU:** MULTU with the same operands gives hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- **Divide by zero:**
  - DIV rs=-7, rt=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
  - DIVU 7/2 gives lo=3, hi=1.
  - DIVU by 0 leaves the previous hi/lo unchanged, with `busy` still 10 cycles.
- **Stall and back-to-back:** `id_is_md`=1 (mflo) throughout a MULT.
  - `md_stall`=1 in the accept cycle and all 5 busy cycles, then 0 in the cycle after commit.
  - A MULT started in the commit+1 cycle is accepted.
- **Move and ignored start:**
  - MTHI rs=0x12345678 in IDLE gives hi=0x12345678 next cycle with `busy`=0.
  - MTLO issued while BUSY is ignored, and `lo` gets only the in-flight result.
- **Reset mid-operation:** reset asserted at busy cycle 3 of a DIV.
  - The next cycle has `busy`=0, hi=lo=0.
  - No later commit occurs.
